dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator between the core's execute stage and the byte-addressed, word-ported data memory.
- Accepts one load or store request at a time: byte, halfword or word; signed or unsigned loads.
- Drives the memory's Address/WriteData/MemWrite/MemRead port and captures its registered ReadData.
- The memory only writes whole words, so sub-word stores are done as read-modify-write.

Parameters:
- MEM_BYTES, 256, memory depth in bytes (power of 2). A request with addr >= MEM_BYTES is an error when RANGE_CHECK=1.
- RANGE_CHECK, 1, 1 = flag out-of-range addresses as errors; 0 = pass the upper address bits through unchecked.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  sign-extend loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, little-endian: byte A+k = req_wdata[8k+7:8k]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned, illegal size or out of range
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- mem_addr  out  32  {addr[31:2],2'b00}; always word-aligned
- mem_wdata  out  32  byte A+k driven on [31-8k:24-8k] (byte-swapped)
- mem_write  out  2  2'b01 = write strobe, else 2'b00
- mem_read  out  2  2'b01 = read strobe, else 2'b00
- mem_rdata  in  32  memory read data: byte A+k on [8k+7:8k]; valid the cycle after the read strobe edge

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; req_ready=1.
  - resp_valid, resp_err, resp_rdata, mem_read, mem_write and mem_wdata all go to 0 immediately.
  - Any in-flight write is abandoned; no strobe is presented at the next edge.
- Accept: req_valid & req_ready at an edge latches we/size/signed/addr/wdata. req_ready drops the following cycle.
- Error check at accept, in this order: size=3; half with addr[0]=1; word with addr[1:0]!=0; RANGE_CHECK and addr>=MEM_BYTES.
  - On error go to ERR: one cycle, resp_valid=1, resp_err=1, resp_rdata=0.
  - No memory strobe is issued for an errored request.
- States: IDLE, RD, CAP, MERGE, WR, then back to IDLE.
  - mem_read=01 only in RD; mem_write=01 only in WR.
  - Strobes are decoded from the state register and never overlap.
- Load: IDLE, RD, CAP, IDLE.
  - At the edge ending CAP, extract from mem_rdata and register resp_rdata with resp_valid=1.
  - Response appears 2 cycles after the accept edge.
  - Extraction at offset o=addr[1:0]: byte = mem_rdata[8o+7:8o]; half = mem_rdata[8o+15:8o]; word = mem_rdata.
  - Zero- or sign-extend per req_signed.
- Word store: IDLE, WR, IDLE.
  - mem_wdata = byteswap(req_wdata); commit at the edge ending WR.
  - resp_valid=1 the next cycle (1 cycle after accept), resp_rdata=0.
- Sub-word store: IDLE, RD, MERGE, WR, IDLE.
  - In MERGE, replace the addressed lanes of mem_rdata with the low byte/half of req_wdata and register the result into a merge buffer.
  - In WR, mem_wdata = byteswap(buffer).
  - Response 3 cycles after accept.
- resp_valid is a single-cycle pulse, coincident with IDLE. A new request may be accepted in that same cycle (back-to-back).
- resp_rdata holds its value until the next response.
- Reset asserted in any state: the request is dropped with no response; memory is untouched unless the write edge already occurred.

Test Plan:
- Memory preloaded with word@20=0x55555555 and word@40=0xAAAAAAAA. LW 40 -> resp_rdata=0xAAAAAAAA, resp_err=0, resp_valid 2 cycles after accept, exactly one mem_read pulse.
- LB signed @41 -> 0xFFFFFFAA. LBU @41 -> 0x000000AA. LH signed @22 -> 0x00005555. LHU @42 -> 0x0000AAAA.
- SW 8, 0x11223344 -> mem_wdata=0x44332211 with one mem_write pulse. Then LW 8 -> 0x11223344.
- SB @21 data 0x000000EE -> mem_read then mem_write, response 3 cycles after accept. Then LW 20 -> 0x5555EE55. SH @42 0xBEEF -> LW 40 = 0xBEEFAAAA.
- LW @22, LH @23, size=3, and (RANGE_CHECK=1) LW @256 -> each gives resp_err=1, resp_rdata=0, response 1 cycle after accept, no strobes.
- rst_n pulsed low during MERGE of SB @20 -> outputs 0 immediately, no mem_write, no resp_valid. Then LW 20 -> 0x55555555. Back-to-back LW 20 / LW 40 accepted on consecutive response cycles -> both correct.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between execute and a word-ported data memory.
// Sub-word stores are read-modify-write; loads extract and extend one lane.
module dmem_lsu_lane (
  input  logic       be,
  input  logic [7:0] rbyte,
  input  logic [7:0] wbyte,
  output logic [7:0] mbyte
);
  assign mbyte = be ? wbyte : rbyte;
endmodule

module dmem_lsu #(
  parameter int MEM_BYTES   = 256,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_write,
  output logic [1:0]  mem_read,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_MERGE, S_WR, S_ERR} state_t;
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] buf_q, buf_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept, req_err;
  logic [1:0]  off;
  logic [31:0] sh, ext;
  logic [NUM_LANES-1:0]       be;
  logic [NUM_LANES-1:0][7:0]  wlane, merged;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign off       = req_q.addr[1:0];

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)                              req_err = 1'b1;
    else if (req_size == 2'd1 && req_addr[0])          req_err = 1'b1;
    else if (req_size == 2'd2 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    else if (RANGE_CHECK && req_addr >= 32'(MEM_BYTES))  req_err = 1'b1;
  end

  // Load extraction: shift the addressed lane down, then extend.
  always_comb begin
    sh  = mem_rdata >> {off, 3'b000};
    ext = mem_rdata;
    case (req_q.size)
      2'd0:    ext = req_q.sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'b0, sh[7:0]};
      2'd1:    ext = req_q.sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  // Store merge: each lane either keeps the memory byte or takes store data.
  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign be[k]    = (req_q.size == 2'd0) ? (off == 2'(k)) : (off[1] == 1'(k >> 1));
      assign wlane[k] = (req_q.size == 2'd1 && (k % 2) == 1) ? req_q.wdata[15:8]
                                                              : req_q.wdata[7:0];
      dmem_lsu_lane u_lane (
        .be    (be[k]),
        .rbyte (mem_rdata[8*k +: 8]),
        .wbyte (wlane[k]),
        .mbyte (merged[k])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    buf_d        = buf_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        req_d = '{we: req_we, size: req_size, sgn: req_signed,
                  addr: req_addr, wdata: req_wdata};
        if (req_err)              state_d = S_ERR;
        else if (!req_we)         state_d = S_RD;
        else if (req_size == 2'd2) begin
          buf_d   = req_wdata;
          state_d = S_WR;
        end else                  state_d = S_RD;
      end
      S_RD:    state_d = req_q.we ? S_MERGE : S_CAP;
      S_CAP: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ext;
        state_d      = S_IDLE;
      end
      S_MERGE: begin
        buf_d   = merged;
        state_d = S_WR;
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      buf_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      buf_q        <= buf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Strobes come straight from the state register so reset kills them at once.
  assign mem_read   = {1'b0, state_q == S_RD};
  assign mem_write  = {1'b0, state_q == S_WR};
  assign mem_addr   = {req_q.addr[31:2], 2'b00};
  assign mem_wdata  = (state_q == S_WR) ? {buf_q[7:0], buf_q[15:8], buf_q[23:16], buf_q[31:24]}
                                        : 32'h0;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory and a response scoreboard.
module tb_dmem_lsu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_write, mem_read;

  dmem_lsu #(.MEM_BYTES(256), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic [31:0] last_wdata = '0;
  int cyc = 0, nrd = 0, nwr = 0;
  int checks = 0, errors = 0;

  // Memory: registered read, whole-word write; write port is byte-swapped.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read == 2'b01) begin
      mem_rdata <= mem[mem_addr[7:2]];
      nrd <= nrd + 1;
    end
    if (mem_write == 2'b01) begin
      mem[mem_addr[7:2]] <= {mem_wdata[7:0], mem_wdata[15:8], mem_wdata[23:16], mem_wdata[31:24]};
      last_wdata <= mem_wdata;
      nwr <= nwr + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;
  exp_t sb[$];
  int   acc_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] er, input logic ee, input int lat,
                       input int rd, input int wr);
    exp_t e;
    e.rdata = er; e.err = ee; e.lat = lat; e.rd = rd; e.wr = wr;
    sb.push_back(e);
    nrd = 0; nwr = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    chk("ready_drops", 32'(req_ready), 32'd0);
  endtask

  // Returns at the negedge where resp_valid is seen.
  task automatic wait_resp(input string tag);
    exp_t e;
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, "_timeout"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
      chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'(e.lat));
      chk({tag, "_nrd"}, 32'(nrd), 32'(e.rd));
      chk({tag, "_nwr"}, 32'(nwr), 32'(e.wr));
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] er, input logic ee, input int lat,
                     input int rd, input int wr);
    issue(we, size, sgn, addr, wdata, er, ee, lat, rd, wr);
    wait_resp(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_hold"}, resp_rdata, er);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[5]  = 32'h55555555;
    mem[10] = 32'hAAAAAAAA;
    mem_rdata = '0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn("lw40",  1'b0, 2'd2, 1'b0, 32'd40, '0, 32'hAAAAAAAA, 1'b0, 2, 1, 0);
    txn("lb41",  1'b0, 2'd0, 1'b1, 32'd41, '0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    txn("lbu41", 1'b0, 2'd0, 1'b0, 32'd41, '0, 32'h000000AA, 1'b0, 2, 1, 0);
    txn("lh22",  1'b0, 2'd1, 1'b1, 32'd22, '0, 32'h00005555, 1'b0, 2, 1, 0);
    txn("lhu42", 1'b0, 2'd1, 1'b0, 32'd42, '0, 32'h0000AAAA, 1'b0, 2, 1, 0);
    txn("lh42",  1'b0, 2'd1, 1'b1, 32'd42, '0, 32'hFFFFAAAA, 1'b0, 2, 1, 0);

    // Reset during MERGE of a byte store: nothing is written, no response.
    nrd = 0; nwr = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd20; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk("rstm_ready", 32'(req_ready), 32'd1);
    chk("rstm_strobes", {resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    chk("rstm_wdata", mem_wdata, 32'd0);
    chk("rstm_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstm_noresp", 32'(resp_valid), 32'd0);
    end
    chk("rstm_nwr", 32'(nwr), 32'd0);
    txn("lw20a", 1'b0, 2'd2, 1'b0, 32'd20, '0, 32'h55555555, 1'b0, 2, 1, 0);

    txn("sw8",   1'b1, 2'd2, 1'b0, 32'd8, 32'h11223344, 32'h0, 1'b0, 1, 0, 1);
    chk("sw8_wdata", last_wdata, 32'h44332211);
    txn("lw8",   1'b0, 2'd2, 1'b0, 32'd8, '0, 32'h11223344, 1'b0, 2, 1, 0);
    txn("sb21",  1'b1, 2'd0, 1'b0, 32'd21, 32'h000000EE, 32'h0, 1'b0, 3, 1, 1);
    txn("lw20b", 1'b0, 2'd2, 1'b0, 32'd20, '0, 32'h5555EE55, 1'b0, 2, 1, 0);
    txn("sh42",  1'b1, 2'd1, 1'b0, 32'd42, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1);
    txn("lw40b", 1'b0, 2'd2, 1'b0, 32'd40, '0, 32'hBEEFAAAA, 1'b0, 2, 1, 0);

    txn("e_lw22",  1'b0, 2'd2, 1'b0, 32'd22,  '0, 32'h0, 1'b1, 1, 0, 0);
    txn("e_lh23",  1'b0, 2'd1, 1'b0, 32'd23,  '0, 32'h0, 1'b1, 1, 0, 0);
    txn("e_sz3",   1'b1, 2'd3, 1'b0, 32'd0,   '0, 32'h0, 1'b1, 1, 0, 0);
    txn("e_lw256", 1'b0, 2'd2, 1'b0, 32'd256, '0, 32'h0, 1'b1, 1, 0, 0);

    // Back-to-back: second request accepted in the first response cycle.
    issue(1'b0, 2'd2, 1'b0, 32'd20, '0, 32'h5555EE55, 1'b0, 2, 1, 0);
    wait_resp("b2b_a");
    issue(1'b0, 2'd2, 1'b0, 32'd40, '0, 32'hBEEFAAAA, 1'b0, 2, 1, 0);
    wait_resp("b2b_b");
    @(negedge clk);
    chk("b2b_pulse", 32'(resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
